// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding, parity modes
// and a frame-length helper for the TX/RX blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int frame_bits(
        input int data_bits,
        input int parity,
        input int stop_bits
    );
        return 1 + data_bits + stop_bits
             + ((parity != PAR_NONE) ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Write-side handshake and status bundle of the buffered UART
// transmitter.
interface uart_tx_buf_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          i_Tx_DV;
    logic [7:0]    i_Tx_Byte;
    logic          o_Tx_Ready;
    logic          o_Tx_Serial;
    logic          o_Tx_Active;
    logic          o_Tx_Done;
    logic          o_Overflow;
    logic [CW-1:0] o_Fifo_Count;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active,
        input  o_Tx_Done, o_Overflow, o_Fifo_Count
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Serial, o_Tx_Active,
        output o_Tx_Done, o_Overflow, o_Fifo_Count
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is refused
// whenever the FIFO is full at the start of the cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers are exactly AW bits wide so they wrap on their own.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: write FIFO feeding a serialiser
// with optional parity and one or two stop bits.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    uart_tx_buf_if.slave bus
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);

    tx_state_t     state, state_nxt;
    logic [15:0]   clk_cnt, clk_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par_q, par_nxt;
    logic          fin_q, fin_nxt;
    logic          line;
    logic          bit_end;
    logic          serial_q, active_q, done_q, ovf_q;
    logic          push, pop, full, empty;
    logic [7:0]    head, head_m;
    logic [CW-1:0] count;

    assign push   = bus.i_Tx_DV && !full && !i_Reset;
    assign head_m = head & DATA_MASK;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .push    (push),
        .wdata   (bus.i_Tx_Byte),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign bit_end = (clk_cnt == BIT_LAST);

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = bit_end ? '0 : clk_cnt + 16'd1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        par_nxt     = par_q;
        fin_nxt     = 1'b0;
        pop         = 1'b0;
        line        = 1'b1;
        unique case (state)
            ST_IDLE: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_nxt = head_m;
                    par_nxt   = (PARITY == PAR_ODD) ? ~^head_m
                                                    : ^head_m;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                line = 1'b0;
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                line = shreg[0];
                if (bit_end) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_nxt = '0;
                        state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY
                                                           : ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                line = par_q;
                if (bit_end) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // Stop bits are counted in bit_idx to keep clk_cnt at 16 bits.
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_nxt = '0;
                        fin_nxt     = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state    <= ST_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            fin_q    <= 1'b0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            clk_cnt  <= clk_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            par_q    <= par_nxt;
            fin_q    <= fin_nxt;
            serial_q <= line;
            active_q <= (state != ST_IDLE);
            done_q   <= fin_q;
            ovf_q    <= bus.i_Tx_DV && full;
        end
    end

    assign bus.o_Tx_Ready   = !full;
    assign bus.o_Tx_Serial  = serial_q;
    assign bus.o_Tx_Active  = active_q;
    assign bus.o_Tx_Done    = done_q;
    assign bus.o_Overflow   = ovf_q;
    assign bus.o_Fifo_Count = count;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: four configurations at
// CLKS_PER_BIT=4, line traced cycle by cycle.
module tb_uart_tx_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    int         sel = 0;
    int         total = 0;
    int         bad = 0;

    logic [7:0]  wq [6];
    int          ce [7];
    logic [15:0] frames [5];

    logic        m_ser, m_done, m_act, m_ovf, m_rdy;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    uart_tx_buf_if #(.FIFO_DEPTH(16)) b0 ();
    uart_tx_buf_if #(.FIFO_DEPTH(16)) b1 ();
    uart_tx_buf_if #(.FIFO_DEPTH(16)) b2 ();
    uart_tx_buf_if #(.FIFO_DEPTH(4))  b3 ();

    assign b0.i_Tx_DV   = dv && (sel == 0);
    assign b1.i_Tx_DV   = dv && (sel == 1);
    assign b2.i_Tx_DV   = dv && (sel == 2);
    assign b3.i_Tx_DV   = dv && (sel == 3);
    assign b0.i_Tx_Byte = tx_byte;
    assign b1.i_Tx_Byte = tx_byte;
    assign b2.i_Tx_Byte = tx_byte;
    assign b3.i_Tx_Byte = tx_byte;

    uart_tx_buf #(.CLKS_PER_BIT(4)) u0 (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (b0)
    );

    uart_tx_buf #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (7),
        .PARITY       (2),
        .STOP_BITS    (2)
    ) u1 (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (b1)
    );

    uart_tx_buf #(.CLKS_PER_BIT(4), .PARITY(1)) u2 (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (b2)
    );

    uart_tx_buf #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u3 (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (b3)
    );

    always_comb begin
        m_ser  = b0.o_Tx_Serial;
        m_done = b0.o_Tx_Done;
        m_act  = b0.o_Tx_Active;
        m_ovf  = b0.o_Overflow;
        m_rdy  = b0.o_Tx_Ready;
        m_cnt  = 32'(b0.o_Fifo_Count);
        unique case (sel)
            1: begin
                m_ser  = b1.o_Tx_Serial;
                m_done = b1.o_Tx_Done;
                m_act  = b1.o_Tx_Active;
                m_ovf  = b1.o_Overflow;
                m_rdy  = b1.o_Tx_Ready;
                m_cnt  = 32'(b1.o_Fifo_Count);
            end
            2: begin
                m_ser  = b2.o_Tx_Serial;
                m_done = b2.o_Tx_Done;
                m_act  = b2.o_Tx_Active;
                m_ovf  = b2.o_Overflow;
                m_rdy  = b2.o_Tx_Ready;
                m_cnt  = 32'(b2.o_Fifo_Count);
            end
            3: begin
                m_ser  = b3.o_Tx_Serial;
                m_done = b3.o_Tx_Done;
                m_act  = b3.o_Tx_Active;
                m_ovf  = b3.o_Overflow;
                m_rdy  = b3.o_Tx_Ready;
                m_cnt  = 32'(b3.o_Fifo_Count);
            end
            default: ;
        endcase
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Writes wq[0..nw-1] on consecutive edges, then traces nf frames
    // of nb bits each, expecting one idle clock between frames.
    task automatic run(
        input string tag,
        input int    nf,
        input int    nb,
        input int    nw,
        input int    ovf_k,
        input int    depth
    );
        int   per, j, off, last;
        logic e_ser, e_done, e_act;
        per  = 4 * nb + 1;
        last = 2 + nf * per + 4;
        @(negedge clk);
        dv      = 1'b1;
        tx_byte = wq[0];
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            e_ser  = 1'b1;
            e_done = 1'b0;
            e_act  = 1'b0;
            if (k >= 2) begin
                j   = (k - 2) / per;
                off = (k - 2) % per;
                if (j < nf && off < 4 * nb) begin
                    e_ser = frames[j][off / 4];
                    e_act = 1'b1;
                end
                if (j < nf && off == 4 * nb) e_done = 1'b1;
            end
            chk($sformatf("%s ser k=%0d", tag, k), 32'(m_ser), 32'(e_ser));
            chk($sformatf("%s done k=%0d", tag, k), 32'(m_done), 32'(e_done));
            chk($sformatf("%s act k=%0d", tag, k), 32'(m_act), 32'(e_act));
            chk($sformatf("%s ovf k=%0d", tag, k), 32'(m_ovf),
                32'(k == ovf_k));
            if (k < 7) begin
                chk($sformatf("%s cnt k=%0d", tag, k), m_cnt, 32'(ce[k]));
                chk($sformatf("%s rdy k=%0d", tag, k), 32'(m_rdy),
                    32'(ce[k] < depth));
            end
            dv      = (k + 1 < nw);
            tx_byte = (k + 1 < nw) ? wq[k + 1] : 8'h00;
        end
        chk($sformatf("%s cnt end", tag), m_cnt, 32'd0);
    endtask

    initial begin
        sel     = 0;
        rst     = 1'b1;
        dv      = 1'b1;
        tx_byte = 8'h5A;
        repeat (3) @(negedge clk);
        chk("rst ser", 32'(m_ser), 32'd1);
        chk("rst rdy", 32'(m_rdy), 32'd1);
        chk("rst act", 32'(m_act), 32'd0);
        chk("rst done", 32'(m_done), 32'd0);
        chk("rst ovf", 32'(m_ovf), 32'd0);
        chk("rst cnt", m_cnt, 32'd0);
        rst = 1'b0;
        dv  = 1'b0;
        @(negedge clk);
        chk("rst wr ignored", m_cnt, 32'd0);
        chk("rst ser idle", 32'(m_ser), 32'd1);
        repeat (2) @(negedge clk);

        ce = '{1, 0, 0, 0, 0, 0, 0};

        // 0xA5: start, 1,0,1,0,0,1,0,1, stop (LSB = first on line)
        sel       = 0;
        wq[0]     = 8'hA5;
        frames[0] = 16'b1101001010;
        run("a5", 1, 10, 1, -1, 16);

        // 0x83, 7 bits even: start, 1,1,0,0,0,0,0, par 0, stop, stop
        sel       = 1;
        wq[0]     = 8'h83;
        frames[0] = 16'b11000000110;
        run("d7e2", 1, 11, 1, -1, 16);

        // odd parity: 0x00 -> par 1, 0x01 -> par 0
        sel       = 2;
        wq[0]     = 8'h00;
        frames[0] = 16'b11000000000;
        run("odd00", 1, 11, 1, -1, 16);
        wq[0]     = 8'h01;
        frames[0] = 16'b10000000010;
        run("odd01", 1, 11, 1, -1, 16);

        // depth 4: six writes, first popped at once, sixth dropped
        sel = 3;
        wq  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        ce  = '{1, 1, 2, 3, 4, 4, 4};
        for (int i = 0; i < 5; i++) frames[i] = {7'd0, 1'b1, wq[i], 1'b0};
        run("fifo4", 5, 10, 6, 5, 4);

        // reset in DATA bit 3 of frame 1 with two bytes queued
        sel = 0;
        @(negedge clk);
        dv      = 1'b1;
        tx_byte = 8'h00;
        @(negedge clk);
        tx_byte = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        dv = 1'b0;
        chk("mid cnt k=2", m_cnt, 32'd2);
        repeat (16) @(negedge clk);
        chk("mid ser bit3", 32'(m_ser), 32'd0);
        chk("mid act", 32'(m_act), 32'd1);
        chk("mid cnt k=18", m_cnt, 32'd2);
        rst = 1'b1;
        dv  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dv  = 1'b0;
        chk("abort ser", 32'(m_ser), 32'd1);
        chk("abort cnt", m_cnt, 32'd0);
        chk("abort act", 32'(m_act), 32'd0);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            chk($sformatf("post ser k=%0d", k), 32'(m_ser), 32'd1);
            chk($sformatf("post done k=%0d", k), 32'(m_done), 32'd0);
            chk($sformatf("post act k=%0d", k), 32'(m_act), 32'd0);
            chk($sformatf("post cnt k=%0d", k), m_cnt, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417: clocks per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: transmit FIFO entries; power of 2, 2..256.
REQ-006 SHALL have port i_Clock, input, 1: the single clock, rising edge.
REQ-007 SHALL have port i_Reset, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port i_Tx_DV, input, 1: write strobe for i_Tx_Byte.
REQ-009 SHALL have port i_Tx_Byte, input, 8: byte to send; bits above DATA_BITS-1 are ignored.
REQ-010 SHALL have port o_Tx_Ready, output, 1: high when the FIFO is not full.
REQ-011 SHALL have port o_Tx_Serial, output, 1: serial line, registered.
REQ-012 SHALL have port o_Tx_Active, output, 1: high while a frame is being sent (START through STOP).
REQ-013 SHALL have port o_Tx_Done, output, 1: one-cycle pulse at the end of each frame.
REQ-014 SHALL have port o_Overflow, output, 1: one-cycle pulse when a write is dropped.
REQ-015 SHALL have port o_Fifo_Count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-016 Write acceptance SHALL be i_Tx_DV && o_Tx_Ready; o_Tx_Ready SHALL be the FIFO-not-full state at the start of the cycle.
REQ-017 A write while full SHALL be dropped and SHALL pulse o_Overflow in the next cycle; FIFO contents are unchanged.
REQ-018 A pop in the same cycle as a write to a full FIFO SHALL NOT make room for that write; the write is rejected.
REQ-019 A simultaneous accepted write and pop SHALL leave o_Fifo_Count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE: o_Tx_Serial=1. If the FIFO is non-empty, pop the head into the shift register and go to START; otherwise stay in IDLE.
REQ-022 START: o_Tx_Serial=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-023 DATA: send DATA_BITS bits LSB first, each for CLKS_PER_BIT cycles; then go to PARITY if PARITY!=0, else to STOP.
REQ-024 PARITY: send one bit for CLKS_PER_BIT cycles; odd = XNOR-reduce of the data bits, even = XOR-reduce of the data bits.
REQ-025 STOP: o_Tx_Serial=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE with o_Tx_Done=1 in the first IDLE cycle.
REQ-026 Latency: with IDLE and an empty FIFO, the first start-bit cycle SHALL be 2 clocks after the accepting write edge.
REQ-027 Back-to-back frames: with the FIFO non-empty at the end of STOP, exactly one idle-high clock SHALL separate consecutive frames.
REQ-028 The bit counter SHALL be 16 bits and SHALL reset to 0 at every bit boundary; the bit index SHALL be 3 bits.
REQ-029 o_Tx_Active SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.

Reset
REQ-030 On i_Reset=1 at a clock edge: state=IDLE, FIFO emptied (count 0), counters 0, o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0.
REQ-031 Reset mid-frame SHALL abort the frame immediately (line high the next cycle) and discard all queued bytes; writes in reset cycles are ignored.

Structure
REQ-032 Shared package uart_pkg SHALL hold the state encoding, the parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and a frame-length function.
REQ-033 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), reusable by a future RX block.

Verification (bench: CLKS_PER_BIT=4)
REQ-034 Defaults, write 0xA5 -> line low 4 clk, then 1,0,1,0,0,1,0,1 each 4 clk, high 4 clk; o_Tx_Done pulse 42 clk after the write edge.
REQ-035 DATA_BITS=7, PARITY=2, STOP_BITS=2, write 0x83 -> data bits 1,1,0,0,0,0,0, parity 0, 8 clk high; frame 44 clk long.
REQ-036 PARITY=1, write 0x00 -> parity bit 1; write 0x01 -> parity bit 0.
REQ-037 FIFO_DEPTH=4, 6 consecutive writes while idle -> first byte starts sending, 4 queued, o_Tx_Ready low, 1 o_Overflow pulse; 5 frames sent, each separated by 1 idle clock.
REQ-038 Assert i_Reset during the DATA bit 3 of frame 1 with 2 bytes queued -> line high next cycle, o_Fifo_Count=0, no o_Tx_Done pulse, no further frames.
